// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch front end.
//
// Owns the fetch-side PC. Issues word reads to instruction memory over a
// req/gnt + in-order rvalid bus, pairs each returned word with the address it
// was fetched from, buffers the pair in a small FIFO and presents it to decode
// over a valid/ready handshake. A redirect from execute flushes everything
// and restarts fetch at the new target. Responses that were already in flight
// at the time of the redirect are counted and discarded on arrival.
//
// Ports:
//   clk, rst_n           clock (posedge) and asynchronous active-low reset
//   i_redirect           flush and restart fetch at i_redirect_pc
//   i_redirect_pc        new fetch address
//   o_imem_req           read request valid
//   o_imem_addr          byte address of the requested word ([1:0] = 0)
//   i_imem_gnt           request accepted this cycle (when o_imem_req = 1)
//   i_imem_rvalid        read data valid (in order, >= 1 cycle after gnt)
//   i_imem_rdata         instruction word
//   o_if_valid           instruction available to decode
//   i_if_ready           decode accepts the presented instruction
//   o_if_pc, o_if_instr  PC and word of the presented instruction
//   o_if_misalign        (IFETCH_ALIGN_CHK_EN only) presented entry is a
//                        misaligned-redirect marker, not a fetched word
//
// Build option: define IFETCH_ALIGN_CHK_EN to trap misaligned redirect
// targets. Without it the low two target bits are ignored.

module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
`ifdef IFETCH_ALIGN_CHK_EN
  ,
  output logic        o_if_misalign
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Control state (reset)
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [QW-1:0] r_pcq_wptr;
  logic [QW-1:0] r_pcq_rptr;
  logic          r_stall;

  // Datapath storage (not reset; qualified by the control state)
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic          r_fifo_mis   [FIFO_DEPTH];
  logic [31:0]   r_pcq        [MAX_OUTST];

  logic [31:0]   w_tgt_pc;
  logic          w_misalign;
  logic [CW:0]   w_inflight;
  logic          w_issue;
  logic          w_resp;
  logic          w_keep;
  logic          w_pop;
  logic          w_fifo_wr;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_pc;
  logic [31:0]   w_wr_instr;
  logic          w_wr_mis;
  logic [QW-1:0] w_pcq_wnext;
  logic [QW-1:0] w_pcq_rnext;

`ifdef IFETCH_ALIGN_CHK_EN
  assign w_tgt_pc   = i_redirect_pc;
  assign w_misalign = |i_redirect_pc[1:0];
`else
  assign w_tgt_pc   = i_redirect_pc & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
`endif

  // Every issued request already owns a FIFO slot, so a returning word can
  // never find the buffer full. Stale (to-be-dropped) requests still hold
  // their reservation until they come back.
  assign w_inflight = {1'b0, r_outst} + {1'b0, r_count};

  // rst_n gates the request so it is low for the whole reset interval.
  assign o_imem_req  = rst_n && !i_redirect && !r_stall &&
                       (w_inflight < (CW+1)'(FIFO_DEPTH)) &&
                       (r_outst < CW'(MAX_OUTST));
  assign o_imem_addr = r_fetch_pc;

  assign w_issue = o_imem_req && i_imem_gnt;
  // An rvalid with nothing outstanding is a protocol error and is ignored.
  assign w_resp  = i_imem_rvalid && (r_outst != '0);
  assign w_keep  = w_resp && (r_drop == '0);
  assign w_pop   = o_if_valid && i_if_ready;

  assign w_pcq_wnext = (r_pcq_wptr == QW'(MAX_OUTST - 1)) ? '0 : r_pcq_wptr + 1'b1;
  assign w_pcq_rnext = (r_pcq_rptr == QW'(MAX_OUTST - 1)) ? '0 : r_pcq_rptr + 1'b1;

  // FIFO write port: a kept response normally, or the misalign marker that a
  // misaligned redirect drops into the freshly flushed buffer at slot 0.
  always_comb begin
    w_fifo_wr  = w_keep && !i_redirect;
    w_wr_idx   = r_wptr;
    w_wr_pc    = r_pcq[r_pcq_rptr];
    w_wr_instr = i_imem_rdata;
    w_wr_mis   = 1'b0;
    if (i_redirect && w_misalign) begin
      w_fifo_wr  = 1'b1;
      w_wr_idx   = '0;
      w_wr_pc    = i_redirect_pc;
      w_wr_instr = 32'h0000_0000;
      w_wr_mis   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pcq_wptr <= '0;
      r_pcq_rptr <= '0;
      r_stall    <= 1'b0;
    end else if (i_redirect) begin
      // Everything still in flight becomes stale; a response arriving in
      // this very cycle is consumed here and needs no further drop.
      r_fetch_pc <= w_tgt_pc;
      r_outst    <= r_outst - CW'(w_resp);
      r_drop     <= r_outst - CW'(w_resp);
      r_pcq_wptr <= '0;
      r_pcq_rptr <= '0;
      r_rptr     <= '0;
      // A pop in this cycle is squashed together with the flush.
      if (w_misalign) begin
        r_wptr  <= AW'(1);
        r_count <= CW'(1);
        r_stall <= 1'b1;
      end else begin
        r_wptr  <= '0;
        r_count <= '0;
        r_stall <= 1'b0;
      end
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pcq_wptr <= w_pcq_wnext;
      end
      r_outst <= r_outst + CW'(w_issue) - CW'(w_resp);
      if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - 1'b1;
      end
      if (w_keep) begin
        r_pcq_rptr <= w_pcq_rnext;
        r_wptr     <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_keep) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_pcq[r_pcq_wptr] <= r_fetch_pc;
    end
    if (w_fifo_wr) begin
      r_fifo_pc[w_wr_idx]    <= w_wr_pc;
      r_fifo_instr[w_wr_idx] <= w_wr_instr;
      r_fifo_mis[w_wr_idx]   <= w_wr_mis;
    end
  end

  // Outputs read as zero while the buffer is empty.
  assign o_if_valid = (r_count != '0);
  assign o_if_pc    = o_if_valid ? r_fifo_pc[r_rptr]    : 32'h0000_0000;
  assign o_if_instr = o_if_valid ? r_fifo_instr[r_rptr] : 32'h0000_0000;
`ifdef IFETCH_ALIGN_CHK_EN
  assign o_if_misalign = o_if_valid && r_fifo_mis[r_rptr];
`else
  logic w_unused_mis;
  assign w_unused_mis = r_fifo_mis[r_rptr];
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: a behavioural instruction memory plus a
// stream-level model of what decode must see (consecutive PCs from the last
// redirect target, each word equal to its address XOR a key).

module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h00400000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUTST  = 2;
  localparam logic [31:0] KEY        = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .o_if_valid   (if_valid),
    .i_if_ready   (if_ready),
    .o_if_pc      (if_pc),
    .o_if_instr   (if_instr)
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    .o_if_misalign(if_misalign)
`endif
  );
`ifndef IFETCH_ALIGN_CHK_EN
  assign if_misalign = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       rq[$];        // granted, not yet answered (includes stale ones)
  logic [31:0] m_fetch;      // address the next request must carry
  logic [31:0] m_exp;        // PC decode must see next
  bit          m_mis_pend;   // misalign marker expected next
  bit          m_stalled;    // marker consumed, nothing may follow
  int          cyc;
  int          n_grant;
  int          p_gnt, p_ready, p_rvalid, max_lat;
  bit          rd_now;
  logic [31:0] rd_pc;
  bit          junk_now;
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] pops[$];
  int          pop_cyc[$];

  task automatic cycle();
    resp_t r;
    bit    junk;
    @(negedge clk);
    redirect    = rd_now;
    redirect_pc = rd_pc;
    rd_now      = 1'b0;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    if_ready    = ($urandom_range(99) < p_ready);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    junk        = junk_now;
    junk_now    = 1'b0;
    if (junk) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEADBEEF;
    end else if (rq.size() > 0 && rq[0].due <= cyc && $urandom_range(99) < p_rvalid) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rq[0].addr ^ KEY;
    end
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (redirect) check_eq("req_in_redirect", imem_req, 0);
    if (imem_req) begin
      check_eq("req_addr", imem_addr, m_fetch);
      check_eq("outst_limit", rq.size() < MAX_OUTST, 1);
      if (m_stalled || m_mis_pend) check_eq("req_while_stalled", imem_req, 0);
    end
    if (if_valid && if_ready && !redirect) begin
      pops.push_back(if_pc);
      pop_cyc.push_back(cyc);
      if (m_stalled) begin
        check_eq("pop_after_misalign", if_valid, 0);
      end else if (m_mis_pend) begin
        check_eq("mis_pc", if_pc, m_exp);
        check_eq("mis_instr", if_instr, 32'h0);
        check_eq("mis_flag", if_misalign, 1);
        m_mis_pend = 1'b0;
        m_stalled  = 1'b1;
      end else begin
        check_eq("if_pc", if_pc, m_exp);
        check_eq("if_instr", if_instr, m_exp ^ KEY);
`ifdef IFETCH_ALIGN_CHK_EN
        check_eq("mis_flag_clr", if_misalign, 0);
`endif
        m_exp = m_exp + 32'd4;
      end
    end
    if (imem_rvalid && !junk) void'(rq.pop_front());
    if (imem_req && imem_gnt) begin
      r.addr = m_fetch;
      r.due  = cyc + 1 + $urandom_range(max_lat);
      rq.push_back(r);
      m_fetch = m_fetch + 32'd4;
      n_grant++;
    end
    if (redirect) begin
      m_stalled  = 1'b0;
      m_mis_pend = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
      m_fetch = redirect_pc;
      m_exp   = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) m_mis_pend = 1'b1;
`else
      m_fetch = redirect_pc & 32'hFFFF_FFFC;
      m_exp   = redirect_pc & 32'hFFFF_FFFC;
`endif
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if_ready    = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_pc", if_pc, 0);
    check_eq("rst_instr", if_instr, 0);
`ifdef IFETCH_ALIGN_CHK_EN
    check_eq("rst_mis", if_misalign, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rq.delete();
    pops.delete();
    pop_cyc.delete();
    m_fetch    = RESET_PC;
    m_exp      = RESET_PC;
    m_mis_pend = 1'b0;
    m_stalled  = 1'b0;
    cyc        = 0;
    n_grant    = 0;
    rd_now     = 1'b0;
    junk_now   = 1'b0;
  endtask

  task automatic knobs(input int g, input int rdy, input int rv, input int lat);
    p_gnt = g; p_ready = rdy; p_rvalid = rv; max_lat = lat;
  endtask

  initial begin
    rd_pc = '0;
    knobs(100, 100, 100, 0);

    // Streaming from reset with single-cycle memory
    do_reset();
    repeat (12) cycle();
    check_eq("t1_n", pops.size() >= 3, 1);
    if (pops.size() >= 3) begin
      check_eq("t1_pc0", pops[0], 32'h00400000);
      check_eq("t1_pc1", pops[1], 32'h00400004);
      check_eq("t1_pc2", pops[2], 32'h00400008);
      check_eq("t1_first_cyc", pop_cyc[0], 2);
      check_eq("t1_b2b", pop_cyc[1], pop_cyc[0] + 1);
    end

    // Decode stalled: buffer fills, requests stop, then drains in order
    do_reset();
    knobs(100, 0, 100, 0);
    repeat (10) cycle();
    check_eq("t2_grants", n_grant, FIFO_DEPTH);
    check_eq("t2_req_off", s_req, 0);
    knobs(100, 100, 100, 0);
    repeat (10) cycle();
    check_eq("t2_n", pops.size() >= 2, 1);
    if (pops.size() >= 2) begin
      check_eq("t2_pc0", pops[0], 32'h00400000);
      check_eq("t2_pc1", pops[1], 32'h00400004);
    end

    // Redirect with two requests in flight; stale data must be dropped
    do_reset();
    knobs(100, 100, 0, 0);
    repeat (2) cycle();
    check_eq("t3_outst", rq.size(), 2);
    rd_now = 1'b1; rd_pc = 32'h00401000;
    cycle();
    cycle();
    knobs(100, 100, 100, 0);
    repeat (12) cycle();
    check_eq("t3_n", pops.size() >= 1, 1);
    if (pops.size() >= 1) check_eq("t3_pc0", pops[0], 32'h00401000);

    // Grant withheld: address held stable
    do_reset();
    knobs(0, 100, 100, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("t4_req", s_req, 1);
      check_eq("t4_addr", s_addr, 32'h00400000);
    end
    knobs(100, 100, 100, 0);
    cycle();
    knobs(0, 100, 100, 0);
    cycle();
    check_eq("t4_addr_next", s_addr, 32'h00400004);

    // Address wrap
    do_reset();
    knobs(100, 100, 100, 0);
    rd_now = 1'b1; rd_pc = 32'hFFFFFFFC;
    repeat (15) cycle();
    check_eq("t5_n", pops.size() >= 2, 1);
    if (pops.size() >= 2) begin
      check_eq("t5_pc0", pops[0], 32'hFFFFFFFC);
      check_eq("t5_pc1", pops[1], 32'h00000000);
    end

    // Misaligned redirect target
    do_reset();
    rd_now = 1'b1; rd_pc = 32'h00400002;
    repeat (8) cycle();
    check_eq("t6_n", pops.size() >= 1, 1);
`ifdef IFETCH_ALIGN_CHK_EN
    check_eq("t6_grants", n_grant, 0);
    check_eq("t6_n1", pops.size(), 1);
    if (pops.size() >= 1) check_eq("t6_pc0", pops[0], 32'h00400002);
    rd_now = 1'b1; rd_pc = 32'h00402000;
    repeat (8) cycle();
    check_eq("t6_resume_n", pops.size() >= 2, 1);
    if (pops.size() >= 2) check_eq("t6_resume_pc", pops[1], 32'h00402000);
`else
    if (pops.size() >= 1) check_eq("t6_pc0", pops[0], 32'h00400000);
`endif

    // Randomized traffic against the stream model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0)
        knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 30),
              $urandom_range(3));
      if ($urandom_range(99) < 3) begin
        rd_now = 1'b1;
`ifdef IFETCH_ALIGN_CHK_EN
        rd_pc = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(3) == 0) ? 32'd2 : 32'd0);
`else
        rd_pc = $urandom();
`endif
      end
      cycle();
    end
    check_eq("rand_progress", pops.size() > 50, 1);

    // Reset in the middle of traffic, then a stray response after release
    knobs(100, 100, 100, 2);
    repeat (3) cycle();
    do_reset();
    knobs(0, 100, 100, 0);
    junk_now = 1'b1;
    cycle();
    for (int i = 0; i < 300; i++) begin
      if (i % 100 == 0)
        knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 30),
              $urandom_range(3));
      cycle();
    end
    check_eq("post_rst_n", pops.size() > 5, 1);
    if (pops.size() > 0) check_eq("post_rst_pc0", pops[0], RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
